// File: rtl/dyser_core.sv
// dyser_core: simplified DySER slice with 8 input FIFOs, a configurable route fabric and 8 output FIFOs.
// Two send lanes and two receive lanes, each with combinational stall back-pressure.
module dyser_core #(
    parameter int DATA_WIDTH = 63,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_WIDTH:0] send_data_r0,
    input  logic [DATA_WIDTH:0] send_data_r1,
    input  logic [2:0]          send_port_r0,
    input  logic [2:0]          send_port_r1,
    input  logic                send_en0,
    input  logic                send_en1,
    input  logic [2:0]          recv_port_r0,
    input  logic [2:0]          recv_port_r1,
    input  logic                recv_en0,
    input  logic                recv_en1,
    input  logic [20:0]         config_bits,
    input  logic                config_en,
    input  logic                commit,
    output logic                send_stall,
    output logic [DATA_WIDTH:0] recv_data_r0,
    output logic [DATA_WIDTH:0] recv_data_r1,
    output logic                recv_stall
);
    localparam int NP       = 8;
    localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    localparam int CFG_LAST = 16;

    // state      | meaning
    // S_UNCONFIG | no configuration loaded since reset
    // S_LOADING  | config words 0..16 being accepted, fabric idle
    // S_ACTIVE   | routes valid, fabric may fire
    typedef enum logic [1:0] {S_UNCONFIG, S_LOADING, S_ACTIVE} state_t;
    typedef logic [DATA_WIDTH:0] word_t;

    state_t        state_q, state_d;
    logic [4:0]    wcnt_q, wcnt_d;
    logic [7:0]    route_q [NP];   // {op[1:0], srcB[2:0], srcA[2:0]}
    logic [7:0]    route_d [NP];
    logic [NP-1:0] rvld_q, rvld_d;

    word_t         in_mem_q  [NP][FIFO_DEPTH];
    word_t         in_mem_d  [NP][FIFO_DEPTH];
    logic [PW-1:0] in_rd_q   [NP];
    logic [PW-1:0] in_rd_d   [NP];
    logic [CW-1:0] in_cnt_q  [NP];
    logic [CW-1:0] in_cnt_d  [NP];
    word_t         out_mem_q [NP][FIFO_DEPTH];
    word_t         out_mem_d [NP][FIFO_DEPTH];
    logic [PW-1:0] out_rd_q  [NP];
    logic [PW-1:0] out_rd_d  [NP];
    logic [CW-1:0] out_cnt_q [NP];
    logic [CW-1:0] out_cnt_d [NP];

    word_t         in_head [NP];
    word_t         result  [NP];
    logic [NP-1:0] in_ne, ref_mask;
    logic          outs_ok, fire;
    logic          same_in, same_out, send_stall_int, recv_stall_int, send_go, recv_go;
    word_t         rd0, rd1;
    logic          unused_cfg;

    assign unused_cfg = ^{config_bits[19:11], config_bits[5:3]};

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        return PW'((int'(p) + n) % FIFO_DEPTH);
    endfunction

    // Fabric: lockstep firing across all valid routes
    always_comb begin
        ref_mask = '0;
        outs_ok  = 1'b1;
        for (int p = 0; p < NP; p++) begin
            in_head[p] = in_mem_q[p][in_rd_q[p]];
            in_ne[p]   = (in_cnt_q[p] != '0);
        end
        for (int k = 0; k < NP; k++) begin
            result[k] = '0;
            if (rvld_q[k]) begin
                ref_mask[route_q[k][2:0]] = 1'b1;
                if (route_q[k][7:6] != 2'b00) ref_mask[route_q[k][5:3]] = 1'b1;
                if (int'(out_cnt_q[k]) >= FIFO_DEPTH) outs_ok = 1'b0;
            end
            case (route_q[k][7:6])
                2'b00:   result[k] = in_head[route_q[k][2:0]];
                2'b01:   result[k] = in_head[route_q[k][2:0]] + in_head[route_q[k][5:3]];
                2'b10:   result[k] = in_head[route_q[k][2:0]] - in_head[route_q[k][5:3]];
                default: result[k] = in_head[route_q[k][2:0]] ^ in_head[route_q[k][5:3]];
            endcase
        end
        fire = (state_q == S_ACTIVE) && (rvld_q != '0) && ((ref_mask & ~in_ne) == '0) && outs_ok;
    end

    always_comb begin
        same_in        = send_en0 && send_en1 && (send_port_r0 == send_port_r1);
        send_stall_int = (send_en0 && int'(in_cnt_q[send_port_r0]) >= FIFO_DEPTH) ||
                         (send_en1 && int'(in_cnt_q[send_port_r1]) + (same_in ? 2 : 1) > FIFO_DEPTH);
        same_out       = recv_en0 && recv_en1 && (recv_port_r0 == recv_port_r1);
        recv_stall_int = (recv_en0 && out_cnt_q[recv_port_r0] == '0) ||
                         (recv_en1 && int'(out_cnt_q[recv_port_r1]) < (same_out ? 2 : 1));
        send_go        = !send_stall_int && !commit;
        recv_go        = !recv_stall_int && !commit;

        rd0 = (out_cnt_q[recv_port_r0] != '0) ? out_mem_q[recv_port_r0][out_rd_q[recv_port_r0]] : '0;
        if (same_out)
            rd1 = (int'(out_cnt_q[recv_port_r1]) >= 2) ?
                  out_mem_q[recv_port_r1][ptr_add(out_rd_q[recv_port_r1], 1)] : '0;
        else
            rd1 = (out_cnt_q[recv_port_r1] != '0) ? out_mem_q[recv_port_r1][out_rd_q[recv_port_r1]] : '0;

        send_stall   = !rst && send_stall_int;
        recv_stall   = !rst && recv_stall_int;
        recv_data_r0 = rst ? '0 : rd0;
        recv_data_r1 = rst ? '0 : rd1;
    end

    always_comb begin
        logic          n0, n1, pop, push, m0, m1;
        logic [PW-1:0] wr;
        in_mem_d  = in_mem_q;
        in_rd_d   = in_rd_q;
        in_cnt_d  = in_cnt_q;
        out_mem_d = out_mem_q;
        out_rd_d  = out_rd_q;
        out_cnt_d = out_cnt_q;
        n0 = 1'b0; n1 = 1'b0; pop = 1'b0; push = 1'b0; m0 = 1'b0; m1 = 1'b0; wr = '0;
        for (int p = 0; p < NP; p++) begin
            n0  = send_go && send_en0 && (send_port_r0 == 3'(p));
            n1  = send_go && send_en1 && (send_port_r1 == 3'(p));
            pop = fire && ref_mask[p];
            wr  = ptr_add(in_rd_q[p], int'(in_cnt_q[p]));
            if (n0) in_mem_d[p][wr] = send_data_r0;
            if (n1) in_mem_d[p][ptr_add(wr, n0 ? 1 : 0)] = send_data_r1;
            in_rd_d[p]  = ptr_add(in_rd_q[p], pop ? 1 : 0);
            in_cnt_d[p] = CW'(int'(in_cnt_q[p]) + int'(n0) + int'(n1) - int'(pop));

            push = fire && rvld_q[p];
            m0   = recv_go && recv_en0 && (recv_port_r0 == 3'(p));
            m1   = recv_go && recv_en1 && (recv_port_r1 == 3'(p));
            if (push) out_mem_d[p][ptr_add(out_rd_q[p], int'(out_cnt_q[p]))] = result[p];
            out_rd_d[p]  = ptr_add(out_rd_q[p], int'(m0) + int'(m1));
            out_cnt_d[p] = CW'(int'(out_cnt_q[p]) + int'(push) - int'(m0) - int'(m1));
        end
        // Commit discards everything in flight, including this cycle's traffic
        if (commit) begin
            for (int p = 0; p < NP; p++) begin
                in_rd_d[p]   = '0;
                in_cnt_d[p]  = '0;
                out_rd_d[p]  = '0;
                out_cnt_d[p] = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        route_d = route_q;
        rvld_d  = rvld_q;
        if (config_en) begin
            if (wcnt_q < 5'd8) begin
                route_d[wcnt_q[2:0]] = {config_bits[10:9], config_bits[8:6], config_bits[2:0]};
                rvld_d[wcnt_q[2:0]]  = config_bits[20];
            end
            if (wcnt_q == 5'(CFG_LAST)) begin
                wcnt_d  = '0;
                state_d = S_ACTIVE;
            end else begin
                wcnt_d  = wcnt_q + 5'd1;
                state_d = S_LOADING;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_UNCONFIG;
            wcnt_q  <= '0;
            rvld_q  <= '0;
            for (int i = 0; i < NP; i++) begin
                route_q[i]   <= '0;
                in_rd_q[i]   <= '0;
                in_cnt_q[i]  <= '0;
                out_rd_q[i]  <= '0;
                out_cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rvld_q    <= rvld_d;
            route_q   <= route_d;
            in_rd_q   <= in_rd_d;
            in_cnt_q  <= in_cnt_d;
            out_rd_q  <= out_rd_d;
            out_cnt_q <= out_cnt_d;
        end
        in_mem_q  <= in_mem_d;
        out_mem_q <= out_mem_d;
    end
endmodule

// File: tb/tb_dyser_core.sv
// Testbench for dyser_core: directed vector table, hand sequences, and random traffic
// checked every cycle against a queue-based reference model.
module tb_dyser_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] send_data_r0, send_data_r1;
    logic [2:0]  send_port_r0, send_port_r1;
    logic        send_en0, send_en1;
    logic [2:0]  recv_port_r0, recv_port_r1;
    logic        recv_en0, recv_en1;
    logic [20:0] config_bits;
    logic        config_en, commit;
    logic        send_stall, recv_stall;
    logic [63:0] recv_data_r0, recv_data_r1;

    dyser_core #(.DATA_WIDTH(63), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .send_data_r0(send_data_r0), .send_data_r1(send_data_r1),
        .send_port_r0(send_port_r0), .send_port_r1(send_port_r1),
        .send_en0(send_en0), .send_en1(send_en1),
        .recv_port_r0(recv_port_r0), .recv_port_r1(recv_port_r1),
        .recv_en0(recv_en0), .recv_en1(recv_en1),
        .config_bits(config_bits), .config_en(config_en), .commit(commit),
        .send_stall(send_stall), .recv_data_r0(recv_data_r0),
        .recv_data_r1(recv_data_r1), .recv_stall(recv_stall)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one queue per FIFO, config words kept verbatim
    logic [63:0] m_in  [8][$];
    logic [63:0] m_out [8][$];
    logic [20:0] m_route [8];
    int          m_state = 0;   // 0 unconfigured, 1 loading, 2 active
    int          m_wcnt  = 0;
    logic        e_sstall, e_rstall;
    logic [63:0] e_r0, e_r1;

    task automatic model_expect();
        int need;
        if (rst) begin
            e_sstall = 1'b0; e_rstall = 1'b0; e_r0 = '0; e_r1 = '0;
            return;
        end
        need = (send_en0 && send_en1 && send_port_r0 == send_port_r1) ? 2 : 1;
        e_sstall = (send_en0 && m_in[send_port_r0].size() >= 4) ||
                   (send_en1 && m_in[send_port_r1].size() + need > 4);
        need = (recv_en0 && recv_en1 && recv_port_r0 == recv_port_r1) ? 2 : 1;
        e_rstall = (recv_en0 && m_out[recv_port_r0].size() == 0) ||
                   (recv_en1 && m_out[recv_port_r1].size() < need);
        e_r0 = (m_out[recv_port_r0].size() > 0) ? m_out[recv_port_r0][0] : 64'd0;
        if (need == 2) e_r1 = (m_out[recv_port_r1].size() >= 2) ? m_out[recv_port_r1][1] : 64'd0;
        else           e_r1 = (m_out[recv_port_r1].size() > 0) ? m_out[recv_port_r1][0] : 64'd0;
    endtask

    task automatic model_update();
        logic        fire, any;
        logic [7:0]  refd;
        logic [63:0] res [8];
        logic [63:0] a, b;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_in[i].delete(); m_out[i].delete(); m_route[i] = '0;
            end
            m_state = 0; m_wcnt = 0;
            return;
        end
        model_expect();
        fire = (m_state == 2);
        any  = 1'b0;
        refd = '0;
        for (int k = 0; k < 8; k++) begin
            res[k] = '0;
            if (m_route[k][20]) begin
                any = 1'b1;
                if (m_in[m_route[k][2:0]].size() == 0) fire = 1'b0;
                if (m_route[k][10:9] != 2'b00 && m_in[m_route[k][8:6]].size() == 0) fire = 1'b0;
                if (m_out[k].size() >= 4) fire = 1'b0;
            end
        end
        fire = fire && any;
        if (fire) begin
            for (int k = 0; k < 8; k++) begin
                if (m_route[k][20]) begin
                    a = m_in[m_route[k][2:0]][0];
                    refd[m_route[k][2:0]] = 1'b1;
                    b = '0;
                    if (m_route[k][10:9] != 2'b00) begin
                        b = m_in[m_route[k][8:6]][0];
                        refd[m_route[k][8:6]] = 1'b1;
                    end
                    case (m_route[k][10:9])
                        2'b00:   res[k] = a;
                        2'b01:   res[k] = a + b;
                        2'b10:   res[k] = a - b;
                        default: res[k] = a ^ b;
                    endcase
                end
            end
        end
        if (commit) begin
            for (int i = 0; i < 8; i++) begin
                m_in[i].delete(); m_out[i].delete();
            end
        end else begin
            if (!e_sstall) begin
                if (send_en0) m_in[send_port_r0].push_back(send_data_r0);
                if (send_en1) m_in[send_port_r1].push_back(send_data_r1);
            end
            if (!e_rstall) begin
                if (recv_en0) void'(m_out[recv_port_r0].pop_front());
                if (recv_en1) void'(m_out[recv_port_r1].pop_front());
            end
            if (fire) begin
                for (int i = 0; i < 8; i++) begin
                    if (refd[i]) void'(m_in[i].pop_front());
                    if (m_route[i][20]) m_out[i].push_back(res[i]);
                end
            end
        end
        if (config_en) begin
            if (m_wcnt < 8) m_route[m_wcnt] = config_bits;
            if (m_wcnt == 16) begin m_wcnt = 0; m_state = 2; end
            else begin m_wcnt++; m_state = 1; end
        end
    endtask

    task automatic cycle();
        #1;
        model_expect();
        chk("model send_stall", 64'(send_stall), 64'(e_sstall));
        chk("model recv_stall", 64'(recv_stall), 64'(e_rstall));
        chk("model recv_data_r0", recv_data_r0, e_r0);
        chk("model recv_data_r1", recv_data_r1, e_r1);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; commit = 1'b0; config_en = 1'b0; config_bits = '0;
        send_en0 = 1'b0; send_en1 = 1'b0; send_port_r0 = '0; send_port_r1 = '0;
        send_data_r0 = '0; send_data_r1 = '0;
        recv_en0 = 1'b0; recv_en1 = 1'b0; recv_port_r0 = '0; recv_port_r1 = '0;
    endtask

    logic [20:0] cfg_w [17];

    task automatic cfg_clear();
        for (int i = 0; i < 17; i++) cfg_w[i] = '0;
    endtask

    task automatic cfg_test1();
        cfg_clear();
        cfg_w[0] = 21'h100007; cfg_w[3] = 21'h100000;
        cfg_w[5] = 21'h100002; cfg_w[7] = 21'h100004;
    endtask

    task automatic load_cfg();
        for (int i = 0; i < 17; i++) begin
            config_en = 1'b1; config_bits = cfg_w[i];
            cycle();
        end
        config_en = 1'b0; config_bits = '0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    task automatic send2(input logic [2:0] p0, input logic [63:0] d0, input logic [2:0] p1, input logic [63:0] d1);
        send_en0 = 1'b1; send_port_r0 = p0; send_data_r0 = d0;
        send_en1 = 1'b1; send_port_r1 = p1; send_data_r1 = d1;
    endtask

    task automatic recv2(input logic [2:0] p0, input logic [2:0] p1);
        recv_en0 = 1'b1; recv_port_r0 = p0; recv_en1 = 1'b1; recv_port_r1 = p1;
    endtask

    typedef struct {
        logic        s_en;
        logic [2:0]  s_p0, s_p1;
        logic [63:0] s_d0, s_d1;
        logic        r_en;
        logic [2:0]  r_p0, r_p1;
        logic        exp_ss, exp_rs;
        logic [63:0] exp_r0, exp_r1;
    } vec_t;

    vec_t t1 [8];

    initial begin
        t1[0] = '{1, 3'd4, 3'd2, 64'd0, 64'd1, 0, 3'd0, 3'd0, 0, 0, 64'd0, 64'd0};
        t1[1] = '{1, 3'd0, 3'd7, 64'd2, 64'd3, 0, 3'd0, 3'd0, 0, 0, 64'd0, 64'd0};
        t1[2] = '{1, 3'd4, 3'd2, 64'd4, 64'd5, 0, 3'd0, 3'd0, 0, 0, 64'd0, 64'd0};
        t1[3] = '{1, 3'd0, 3'd7, 64'd6, 64'd7, 0, 3'd0, 3'd0, 0, 0, 64'd3, 64'd3};
        t1[4] = '{0, 3'd0, 3'd0, 64'd0, 64'd0, 1, 3'd7, 3'd5, 0, 0, 64'd0, 64'd1};
        t1[5] = '{0, 3'd0, 3'd0, 64'd0, 64'd0, 1, 3'd3, 3'd0, 0, 0, 64'd2, 64'd3};
        t1[6] = '{0, 3'd0, 3'd0, 64'd0, 64'd0, 1, 3'd7, 3'd5, 0, 0, 64'd4, 64'd5};
        t1[7] = '{0, 3'd0, 3'd0, 64'd0, 64'd0, 1, 3'd3, 3'd0, 0, 0, 64'd6, 64'd7};

        // Reset state: outputs forced to zero even with requests that would stall
        idle();
        rst = 1'b1; recv_en0 = 1'b1; recv_port_r0 = 3'd2;
        #1;
        chk("reset send_stall", 64'(send_stall), 64'd0);
        chk("reset recv_stall", 64'(recv_stall), 64'd0);
        chk("reset recv_data_r0", recv_data_r0, 64'd0);
        cycle();
        rst = 1'b0;
        #1;
        chk("post-reset recv empty stall", 64'(recv_stall), 64'd1);
        cycle();
        idle();

        // Test 1: straight-through routes
        cfg_test1();
        load_cfg();
        for (int i = 0; i < 8; i++) begin
            idle();
            if (t1[i].s_en) send2(t1[i].s_p0, t1[i].s_d0, t1[i].s_p1, t1[i].s_d1);
            if (t1[i].r_en) recv2(t1[i].r_p0, t1[i].r_p1);
            #1;
            chk($sformatf("t1[%0d] send_stall", i), 64'(send_stall), 64'(t1[i].exp_ss));
            chk($sformatf("t1[%0d] recv_stall", i), 64'(recv_stall), 64'(t1[i].exp_rs));
            chk($sformatf("t1[%0d] recv_data_r0", i), recv_data_r0, t1[i].exp_r0);
            chk($sformatf("t1[%0d] recv_data_r1", i), recv_data_r1, t1[i].exp_r1);
            cycle();
        end
        idle();

        // Test 2: add then subtract with wrap-around
        do_reset();
        cfg_clear(); cfg_w[1] = 21'h1002C1;
        load_cfg();
        send2(3'd1, 64'h10, 3'd3, 64'h5); cycle();
        idle(); cycle();
        recv_en0 = 1'b1; recv_port_r0 = 3'd1;
        #1;
        chk("alu add o1", recv_data_r0, 64'h15);
        chk("alu add stall", 64'(recv_stall), 64'd0);
        cycle(); idle();
        cfg_clear(); cfg_w[1] = 21'h1004C1;
        load_cfg();
        send2(3'd1, 64'h0, 3'd3, 64'h1); cycle();
        idle(); cycle();
        recv_en0 = 1'b1; recv_port_r0 = 3'd1;
        #1;
        chk("alu sub o1", recv_data_r0, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(); idle();

        // Test 3: back-pressure while unconfigured
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            idle();
            send_en0 = 1'b1; send_port_r0 = 3'd1; send_data_r0 = 64'(i);
            if (i == 5) begin send_en1 = 1'b1; send_port_r1 = 3'd5; send_data_r1 = 64'h55; end
            #1;
            chk($sformatf("bp cycle %0d send_stall", i), 64'(send_stall), (i == 5) ? 64'd1 : 64'd0);
            cycle();
        end
        idle();
        cfg_clear(); cfg_w[0] = 21'h100005;
        load_cfg();
        cycle(); cycle();
        recv_en0 = 1'b1; recv_port_r0 = 3'd0;
        #1;
        chk("bp lane1 dropped", 64'(recv_stall), 64'd1);
        cycle(); idle();

        // Test 4: recv on empty output port until data arrives
        cfg_clear(); cfg_w[2] = 21'h100006;
        load_cfg();
        recv_en0 = 1'b1; recv_port_r0 = 3'd2;
        #1; chk("recv empty stall a", 64'(recv_stall), 64'd1); cycle();
        send_en0 = 1'b1; send_port_r0 = 3'd6; send_data_r0 = 64'hABCD;
        #1; chk("recv empty stall b", 64'(recv_stall), 64'd1); cycle();
        send_en0 = 1'b0;
        #1; chk("recv empty stall c", 64'(recv_stall), 64'd1); cycle();
        #1;
        chk("recv arrives stall", 64'(recv_stall), 64'd0);
        chk("recv arrives data", recv_data_r0, 64'hABCD);
        cycle();
        #1; chk("recv popped once", 64'(recv_stall), 64'd1); cycle();
        idle();

        // Test 5: commit flush, then reset in the middle of a config load
        do_reset();
        cfg_test1();
        load_cfg();
        send2(3'd4, 64'd0, 3'd2, 64'd1); cycle();
        send2(3'd0, 64'd2, 3'd7, 64'd3); cycle();
        idle(); commit = 1'b1; cycle();
        idle(); recv2(3'd7, 3'd5);
        #1; chk("commit o7/o5 stall", 64'(recv_stall), 64'd1); cycle();
        idle(); recv2(3'd3, 3'd0);
        #1; chk("commit o3/o0 stall", 64'(recv_stall), 64'd1); cycle();
        idle(); send2(3'd4, 64'd10, 3'd2, 64'd11); cycle();
        send2(3'd0, 64'd12, 3'd7, 64'd13); cycle();
        idle(); cycle();
        recv2(3'd7, 3'd5);
        #1;
        chk("after commit o7", recv_data_r0, 64'd10);
        chk("after commit o5", recv_data_r1, 64'd11);
        chk("after commit stall", 64'(recv_stall), 64'd0);
        cycle();
        idle(); recv2(3'd3, 3'd0);
        #1;
        chk("after commit o3", recv_data_r0, 64'd12);
        chk("after commit o0", recv_data_r1, 64'd13);
        cycle(); idle();
        for (int i = 0; i < 9; i++) begin
            config_en = 1'b1; config_bits = cfg_w[i]; cycle();
        end
        config_bits = cfg_w[9]; rst = 1'b1; recv_en0 = 1'b1; recv_port_r0 = 3'd7;
        #1;
        chk("rst mid-load send_stall", 64'(send_stall), 64'd0);
        chk("rst mid-load recv_stall", 64'(recv_stall), 64'd0);
        cycle();
        idle();
        send2(3'd4, 64'd20, 3'd2, 64'd21); cycle();
        send2(3'd0, 64'd22, 3'd7, 64'd23); cycle();
        idle(); cycle(); cycle();
        recv_en0 = 1'b1; recv_port_r0 = 3'd7;
        #1;
        chk("unconfig no fire stall", 64'(recv_stall), 64'd1);
        chk("unconfig no fire data", recv_data_r0, 64'd0);
        cycle(); idle();

        // Random traffic against the reference model
        do_reset();
        for (int phase = 0; phase < 2; phase++) begin
            cfg_clear();
            for (int k = 0; k < 8; k++) begin
                if (k == 0 || $urandom_range(0, 1) == 1)
                    cfg_w[k] = {1'b1, 9'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)};
                else
                    cfg_w[k] = {1'b0, 20'($urandom)};
            end
            for (int k = 8; k < 17; k++) cfg_w[k] = 21'($urandom);
            load_cfg();
            for (int c = 0; c < 1500; c++) begin
                idle();
                send_en0 = ($urandom_range(0, 1) == 1);
                send_en1 = ($urandom_range(0, 2) == 0);
                send_port_r0 = 3'($urandom_range(0, 7));
                send_port_r1 = 3'($urandom_range(0, 7));
                send_data_r0 = {$urandom, $urandom};
                send_data_r1 = {$urandom, $urandom};
                recv_en0 = ($urandom_range(0, 1) == 1);
                recv_en1 = ($urandom_range(0, 1) == 1);
                recv_port_r0 = 3'($urandom_range(0, 7));
                recv_port_r1 = ($urandom_range(0, 3) == 0) ? recv_port_r0 : 3'($urandom_range(0, 7));
                commit = ($urandom_range(0, 99) == 0);
                cycle();
            end
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
